// File: rtl/keccak_theta_engine.sv
// Keccak theta step applied slice-by-slice to a state held in an external
// single-port memory; only the 5-bit column parity is carried between slices.
module keccak_theta_engine #(
  parameter int SLICES   = 64,
  parameter int ADDR_W   = 6,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [0:24]       in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [0:24]       mem_in,
  output logic              mem_r,
  output logic              mem_w
);

  localparam int Z_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [ADDR_W-1:0] SRC_A  = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A  = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(SRC_BASE + SLICES - 1);
  localparam logic [Z_W-1:0]    Z_LAST = Z_W'(SLICES - 1);

  typedef enum logic [2:0] {
    IDLE, PRE_RD, PRE_CAP, RD, WR, DONE_HOLD
  } state_t;

  state_t         state;
  logic [Z_W-1:0] z;
  logic [4:0]     saved_par;
  logic [4:0]     cur_par;

  function automatic logic [4:0] parity(input logic [0:24] w);
    logic [4:0] p;
    p = '0;
    for (int unsigned x = 0; x < 5; x++)
      for (int unsigned y = 0; y < 5; y++)
        p[x] = p[x] ^ w[5*y + x];
    return p;
  endfunction

  function automatic logic [0:24] theta(input logic [0:24] w,
                                        input logic [4:0]  c,
                                        input logic [4:0]  cp);
    logic [0:24] o;
    o = '0;
    for (int unsigned i = 0; i < 25; i++)
      o[i] = w[i] ^ c[(i % 5 + 4) % 5] ^ cp[(i % 5 + 1) % 5];
    return o;
  endfunction

  always_comb begin
    cur_par = parity(in);
    mem_in  = '0;
    if (state == WR) mem_in = theta(in, cur_par, saved_par);
  end

  // Outputs are assigned on the transition into the state that owns them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      z         <= '0;
      saved_par <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_r     <= 1'b0;
      mem_w     <= 1'b0;
      mem_adr   <= '0;
    end else begin
      case (state)
        IDLE, DONE_HOLD: begin
          mem_r <= 1'b0;
          mem_w <= 1'b0;
          if (start) begin
            state   <= PRE_RD;
            busy    <= 1'b1;
            done    <= 1'b0;
            mem_r   <= 1'b1;
            mem_adr <= LAST_A;
          end
        end
        PRE_RD: begin
          state <= PRE_CAP;
          mem_r <= 1'b0;
        end
        PRE_CAP: begin
          saved_par <= cur_par;
          z         <= '0;
          state     <= RD;
          mem_r     <= 1'b1;
          mem_adr   <= SRC_A;
        end
        RD: begin
          state   <= WR;
          mem_r   <= 1'b0;
          mem_w   <= 1'b1;
          mem_adr <= DST_A + ADDR_W'(z);
        end
        WR: begin
          saved_par <= cur_par;
          mem_w     <= 1'b0;
          if (z == Z_LAST) begin
            state <= DONE_HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            z       <= z + Z_W'(1);
            state   <= RD;
            mem_r   <= 1'b1;
            mem_adr <= SRC_A + ADDR_W'(z) + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_theta_engine.sv
// Bench for keccak_theta_engine: 64-slice in-place and 8-slice out-of-place
// instances, each backed by a behavioural single-port memory.
module tb_keccak_theta_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [0:24] in_a, in_b;
  logic        busy_a, done_a, mem_r_a, mem_w_a;
  logic        busy_b, done_b, mem_r_b, mem_w_b;
  logic [5:0]  adr_a;
  logic [3:0]  adr_b;
  logic [0:24] din_a, din_b;

  logic [0:24] mem_a [64];
  logic [0:24] mem_b [16];
  logic [0:24] st    [64];
  logic [0:24] orig  [64];

  int total = 0, bad = 0;
  int overlap_a = 0, overlap_b = 0;
  int t_done, first_r, first_w, last_w, busy_err;
  logic done_at1;

  always #5 clock = ~clock;

  keccak_theta_engine #(.SLICES(64), .ADDR_W(6), .SRC_BASE(0), .DST_BASE(0)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .in(in_a),
    .busy(busy_a), .done(done_a), .mem_adr(adr_a), .mem_in(din_a),
    .mem_r(mem_r_a), .mem_w(mem_w_a));

  keccak_theta_engine #(.SLICES(8), .ADDR_W(4), .SRC_BASE(0), .DST_BASE(8)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .in(in_b),
    .busy(busy_b), .done(done_b), .mem_adr(adr_b), .mem_in(din_b),
    .mem_r(mem_r_b), .mem_w(mem_w_b));

  always @(posedge clock) begin
    if (mem_w_a) mem_a[adr_a] <= din_a;
    if (mem_r_a) in_a <= mem_a[adr_a];
    if (mem_w_b) mem_b[adr_b] <= din_b;
    if (mem_r_b) in_b <= mem_b[adr_b];
  end

  always @(negedge clock) begin
    if (mem_r_a && mem_w_a) overlap_a++;
    if (mem_r_b && mem_w_b) overlap_b++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference theta on st[0..n-1]: state viewed as a[x][y][z] bits.
  task automatic theta_ref(input int n);
    bit a [5][5][64];
    bit c [5][64];
    for (int z = 0; z < n; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          a[x][y][z] = st[z][5*y + x];
    for (int z = 0; z < n; z++)
      for (int x = 0; x < 5; x++)
        c[x][z] = a[x][0][z] ^ a[x][1][z] ^ a[x][2][z] ^ a[x][3][z] ^ a[x][4][z];
    for (int z = 0; z < n; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          st[z][5*y + x] = a[x][y][z] ^ c[(x + 4) % 5][z] ^ c[(x + 1) % 5][(z + n - 1) % n];
  endtask

  task automatic load_a_from_st();
    for (int i = 0; i < 64; i++) mem_a[i] <= st[i];
    #1;
  endtask

  task automatic run_a(input int p1, input int p2, input int rst_at);
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    t_done = -1; first_r = -1; first_w = -1; last_w = -1; busy_err = 0;
    done_at1 = done_a;
    for (int cnt = 1; cnt <= 1000; cnt++) begin
      if (mem_r_a && first_r < 0) first_r = cnt;
      if (mem_w_a) begin
        if (first_w < 0) first_w = cnt;
        last_w = cnt;
      end
      if (done_a) begin
        t_done = cnt;
        break;
      end
      if (!busy_a) busy_err++;
      if (cnt == p1 || cnt == p2) start_a = 1'b1;
      if (cnt == rst_at) reset = 1'b1;
      @(posedge clock); #1;
      start_a = 1'b0;
      if (cnt == rst_at) begin
        chk("rst_mid_outputs", {busy_a, done_a, mem_r_a, mem_w_a, adr_a, din_a}, '0);
        reset = 1'b0;
        t_done = 0;
        break;
      end
    end
    if (t_done < 0) chk("run_a_timeout", 0, 1);
  endtask

  task automatic check_a(input string tag);
    for (int i = 0; i < 64; i++) chk(tag, mem_a[i], st[i]);
  endtask

  initial begin
    logic [0:24] e;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_a", {busy_a, done_a, mem_r_a, mem_w_a, adr_a, din_a}, '0);
    chk("reset_b", {busy_b, done_b, mem_r_b, mem_w_b, adr_b, din_b}, '0);
    reset = 1'b0;
    @(posedge clock); #1;

    // all-zero in-place with timing
    for (int i = 0; i < 64; i++) st[i] = '0;
    load_a_from_st();
    run_a(0, 0, 0);
    chk("t1_done_cycle", t_done, 131);
    chk("t1_first_rd", first_r, 1);
    chk("t1_first_wr", first_w, 4);
    chk("t1_last_wr", last_w, 130);
    chk("t1_busy_hi", busy_err, 0);
    chk("t1_busy_lo_at_done", busy_a, 0);
    check_a("t1_zero_word");

    // single bit in slice 0
    for (int i = 0; i < 64; i++) st[i] = '0;
    st[0][0] = 1'b1;
    load_a_from_st();
    run_a(0, 0, 0);
    e = '0; e[0] = 1; e[1] = 1; e[6] = 1; e[11] = 1; e[16] = 1; e[21] = 1;
    chk("t2_slice0_const", mem_a[0], e);
    e = '0; e[4] = 1; e[9] = 1; e[14] = 1; e[19] = 1; e[24] = 1;
    chk("t2_slice1_const", mem_a[1], e);
    theta_ref(64);
    check_a("t2_word");

    // wrap-around: single bit in slice 63
    for (int i = 0; i < 64; i++) st[i] = '0;
    st[63][0] = 1'b1;
    load_a_from_st();
    run_a(0, 0, 0);
    e = '0; e[0] = 1; e[1] = 1; e[6] = 1; e[11] = 1; e[16] = 1; e[21] = 1;
    chk("t3_slice63_const", mem_a[63], e);
    e = '0; e[4] = 1; e[9] = 1; e[14] = 1; e[19] = 1; e[24] = 1;
    chk("t3_slice0_const", mem_a[0], e);
    theta_ref(64);
    check_a("t3_word");

    // out-of-place, 8 slices, random
    for (int i = 0; i < 16; i++) begin
      e = 25'($urandom);
      mem_b[i] <= e;
      if (i < 8) begin
        st[i] = e;
        orig[i] = e;
      end
    end
    #1;
    theta_ref(8);
    start_b = 1'b1;
    @(posedge clock); #1;
    start_b = 1'b0;
    t_done = -1;
    for (int cnt = 1; cnt <= 200; cnt++) begin
      if (done_b) begin
        t_done = cnt;
        break;
      end
      @(posedge clock); #1;
    end
    chk("t4_done_cycle", t_done, 19);
    for (int z = 0; z < 8; z++) begin
      chk("t4_dst_word", mem_b[8 + z], st[z]);
      chk("t4_src_kept", mem_b[z], orig[z]);
    end

    // random in-place, ignored mid-pass starts, then back-to-back from DONE_HOLD
    for (int i = 0; i < 64; i++) st[i] = 25'($urandom);
    load_a_from_st();
    run_a(5, 40, 0);
    chk("t5_single_pass_cycle", t_done, 131);
    theta_ref(64);
    check_a("t5_pass1_word");
    run_a(0, 0, 0);
    chk("t5_done_drops", done_at1, 0);
    chk("t5_pass2_cycle", t_done, 131);
    theta_ref(64);
    check_a("t5_pass2_word");

    // reset mid-pass, then a fresh pass
    run_a(0, 0, 50);
    @(posedge clock); #1;
    chk("t6_idle_after_rst", {busy_a, done_a, mem_r_a, mem_w_a}, '0);
    run_a(0, 0, 0);
    chk("t6_fresh_cycle", t_done, 131);
    chk("t6_first_wr", first_w, 4);

    chk("no_rw_overlap_a", overlap_a, 0);
    chk("no_rw_overlap_b", overlap_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/keccak_theta_engine.md
Name: keccak_theta_engine

Overview:
- Parametrised Keccak theta-step engine.
- Works on a state stored slice-by-slice in an external single-port memory: one 25-bit word per slice z, SLICES words in total.
- Streams every slice through a read / compute / write schedule, carrying only the 5-bit column parity between slices.
- Supports in-place or out-of-place operation and any power-of-two slice count. Sits beside the other permutation-step engines on the shared state memory.

Parameters:
- SLICES, 64, number of slices (lane width w); power of two, ≥2
- ADDR_W, 6, memory address width; must satisfy 2^ADDR_W ≥ max(SRC_BASE, DST_BASE) + SLICES
- SRC_BASE, 0, address of slice 0 of the source state
- DST_BASE, 0, address of slice 0 of the destination state; equal to SRC_BASE means in-place

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a theta pass; sampled only in IDLE or DONE_HOLD
- in  in  25  memory read data [0:24]; valid the cycle after mem_r
- busy  out  1  high from accepted start until the pass completes
- done  out  1  level; high after a pass completes, cleared by accepted start or reset
- mem_adr  out  ADDR_W  memory address
- mem_in  out  25  memory write data [0:24]
- mem_r  out  1  read strobe
- mem_w  out  1  write strobe

Behaviour:
- Bit mapping: index i = 5*y + x, for x,y in 0..4. Index 0 is the MSB of [0:24].
- Column parity: C[x] = XOR over y of bit[5y+x].
- Output rule: out[i] = in[i] ^ Cz[x-1 mod 5] ^ Cz-1[x+1 mod 5].
  - Cz is the parity of the current slice's original data.
  - Cz-1 is the parity of slice (z-1) mod SLICES, original (pre-write) data.
- Reset (synchronous), all outputs: busy=0, done=0, mem_r=0, mem_w=0, mem_adr=0, mem_in=0. State = IDLE, z=0, saved parity = 0.
- Reset wins over every other event, including mid-pass. Memory is left partially updated; no recovery.
- States and transitions:
  - IDLE: start=1 → PRE_RD; set busy=1, done=0.
  - PRE_RD: mem_r=1, mem_adr = SRC_BASE + SLICES-1. → PRE_CAP.
  - PRE_CAP: saved parity ← C(in), i.e. the parity of slice SLICES-1. z ← 0. → RD.
  - RD: mem_r=1, mem_w=0, mem_adr = SRC_BASE + z. → WR.
  - WR: mem_w=1, mem_r=0, mem_adr = DST_BASE + z. mem_in = theta(in, C(in), saved parity). Saved parity ← C(in).
    - If z = SLICES-1 → DONE_HOLD.
    - Otherwise z ← z+1 and → RD.
  - DONE_HOLD: busy=0, done=1, strobes 0.
    - start=1 → PRE_RD with done=0, busy=1.
    - Otherwise stay.
- Strobes are registered outputs. mem_r and mem_w are never high in the same cycle. Outside PRE_RD, RD and WR both are 0.
- Timing: mem_in is combinational from in, captured by memory at the end of the WR cycle.
- Wrap-around: slice 0 uses the parity of slice SLICES-1, captured in PRE_CAP before any write, so in-place operation is correct.
  - Slice SLICES-1 is re-read in its own RD cycle. Its own parity therefore comes from still-unmodified data.
- Latency, with start sampled at edge 0:
  - first mem_r at cycle 1;
  - first write at cycle 4;
  - last write at cycle 2 + 2*SLICES;
  - done=1 from cycle 3 + 2*SLICES (131 for SLICES=64).
- start while busy is ignored, with no queuing. start held high in DONE_HOLD launches back-to-back passes.
- z counter width is log2(SLICES). Address arithmetic is modulo 2^ADDR_W.

Test Plan:
- All-zero state, SLICES=64, in-place → all 64 words read back as 0; done rises exactly 131 cycles after start; busy high for cycles 1..130.
- Slice 0 word with only bit 0 set (x=0,y=0), all other slices 0 → slice 0 has bits 0,1,6,11,16,21 set; slice 1 has bits 4,9,14,19,24 set; all other slices 0.
- Wrap case: only bit 0 of slice 63 set → slice 63 has bits 0,1,6,11,16,21 set; slice 0 has bits 4,9,14,19,24 set; the slice 0 result proves the pre-read parity.
- Out-of-place, SLICES=8, SRC_BASE=0, DST_BASE=8, random state → words 8..15 match the software theta model; words 0..7 are unchanged; mem_r and mem_w are never high together.
- start pulsed at cycles 5 and 40 of a pass → ignored, single pass; then start in DONE_HOLD → done drops next cycle and a second pass runs, yielding theta applied twice.
- reset asserted at cycle 50 of a pass → next cycle busy=0, done=0, strobes 0; a fresh start then completes normally in 131 cycles.
